// File: rtl/display_scheduler_if.sv
// Bus between a value producer and the display scheduler: two signed
// sources with update pulses, a hold control, and the registered BCD
// result with its status flags.
interface display_scheduler_if;
  logic [16:0] val_a;
  logic        upd_a;
  logic [16:0] val_b;
  logic        upd_b;
  logic        hold;
  logic [3:0]  dig0;
  logic [3:0]  dig1;
  logic [3:0]  dig2;
  logic [3:0]  dig3;
  logic        neg;
  logic        ovf;
  logic        src;
  logic        busy;

  modport master (
    output val_a, upd_a, val_b, upd_b, hold,
    input  dig0, dig1, dig2, dig3, neg, ovf, src, busy
  );

  modport slave (
    input  val_a, upd_a, val_b, upd_b, hold,
    output dig0, dig1, dig2, dig3, neg, ovf, src, busy
  );
endinterface

// File: rtl/display_scheduler.sv
// Time-shares a sign + four-digit display between two 17-bit signed
// sources. A dwell counter alternates the shown source; each conversion
// runs a 14-step shift-add-3 engine and only DONE updates the outputs.
module display_scheduler #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int MAX_MAG      = 9999
) (
  input  logic               clk,
  input  logic               rst,
  display_scheduler_if.slave bus
);

  localparam int CW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  dwell_q, dwell_d;
  logic           next_src_q, next_src_d;
  logic           pending_q, pending_d;
  logic [13:0]    mag_q;
  logic [15:0]    bcd_q;
  logic [3:0]     cnt_q;
  logic           sgn_q, sat_q, cap_src_q;
  logic [15:0]    dig_q;
  logic           neg_q, ovf_q, src_q, busy_q;

  logic           wrap;
  logic [16:0]    sel_val;
  logic [17:0]    ext_val, mag18;
  logic           load_sat;
  logic [13:0]    load_mag;
  logic [15:0]    bcd_adj;
  logic [29:0]    shifted;

  // Dwell counting, source toggling and the pending-conversion flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    dwell_d    = dwell_q;
    next_src_d = next_src_q;
    wrap       = 1'b0;
    if (!bus.hold) begin
      if (dwell_q == CW'(DWELL_CYCLES - 1)) begin
        dwell_d    = '0;
        next_src_d = ~next_src_q;
        wrap       = 1'b1;
      end else begin
        dwell_d = dwell_q + CW'(1);
      end
    end
    pending_d = pending_q;
    if (state_q == IDLE && pending_q) pending_d = 1'b0;
    // A fresh event wins over the IDLE consume; updates only count for the
    // source that is up next, the other is converted fresh on its turn.
    if (wrap || (bus.upd_a && !next_src_q) || (bus.upd_b && next_src_q))
      pending_d = 1'b1;
  end

  // Operand preparation for LOAD: 18-bit magnitude so -65536 becomes 65536.
  always_comb begin
    sel_val  = next_src_q ? bus.val_b : bus.val_a;
    ext_val  = {sel_val[16], sel_val};
    mag18    = sel_val[16] ? (18'd0 - ext_val) : ext_val;
    load_sat = (mag18 > 18'(MAX_MAG));
    load_mag = load_sat ? 14'(MAX_MAG) : mag18[13:0];
  end

  // One shift-add-3 step: correct nibbles >= 5, then shift the pair left.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                      : bcd_q[i*4 +: 4];
    end
    shifted = {bcd_adj, mag_q} << 1;
  end

  // Dwell and pending registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      dwell_q    <= '0;
      next_src_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      dwell_q    <= dwell_d;
      next_src_q <= next_src_d;
      pending_q  <= pending_d;
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so an aborted conversion leaves nothing behind.
    if (!rst) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      sat_q     <= 1'b0;
      cap_src_q <= 1'b0;
      dig_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      src_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          mag_q     <= load_mag;
          sgn_q     <= sel_val[16];
          sat_q     <= load_sat;
          cap_src_q <= next_src_q;
          bcd_q     <= '0;
          cnt_q     <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, mag_q} <= shifted;
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          dig_q   <= bcd_q;
          neg_q   <= sgn_q;
          ovf_q   <= sat_q;
          src_q   <= cap_src_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dig0 = dig_q[3:0];
  assign bus.dig1 = dig_q[7:4];
  assign bus.dig2 = dig_q[11:8];
  assign bus.dig3 = dig_q[15:12];
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
  assign bus.src  = src_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: vector table, directed multi-cycle
// sequences and randomized conversions against an arithmetic model.
module tb_display_scheduler;

  localparam int DWELL = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scheduler_if bus ();

  display_scheduler #(.DWELL_CYCLES(DWELL), .MAX_MAG(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int unheld   = 0;   // non-held, non-reset cycles since last reset
  int va = 0;
  int vb = 0;

  // Busy-run monitor: records the length of every busy-high stretch.
  int run_len = 0;
  int busy_runs[$];
  always @(negedge clk) begin
    if (bus.busy === 1'b1) run_len++;
    else if (run_len != 0) begin
      busy_runs.push_back(run_len);
      run_len = 0;
    end
  end

  typedef struct {
    int          val;
    logic [15:0] digits;
    logic        neg;
    logic        ovf;
  } vec_t;
  vec_t vecs[10];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    logic h, r;
    h = bus.hold;
    r = rst;
    @(posedge clk);
    if (!r) unheld = 0;
    else if (!h) unheld++;
    #1;
  endtask

  function automatic int model_ns();
    return (unheld / DWELL) % 2;
  endfunction

  function automatic int outs_packed();
    return int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0,
                 bus.neg, bus.ovf, bus.src, bus.busy});
  endfunction

  function automatic int shown_digits();
    return int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0});
  endfunction

  task automatic check_shown(string name, int v, int s);
    int m, exp_bcd, n, o;
    n = (v < 0) ? 1 : 0;
    m = (v < 0) ? -v : v;
    o = (m > 9999) ? 1 : 0;
    if (o != 0) m = 9999;
    exp_bcd = ((m / 1000) << 12) | (((m / 100) % 10) << 8) |
              (((m / 10) % 10) << 4) | (m % 10);
    check({name, "_digits"}, shown_digits(), exp_bcd);
    check({name, "_neg"}, int'(bus.neg), n);
    check({name, "_ovf"}, int'(bus.ovf), o);
    check({name, "_src"}, int'(bus.src), s);
  endtask

  task automatic pulse(int which);
    if (which == 0) bus.upd_a = 1'b1; else bus.upd_b = 1'b1;
    tick();
    bus.upd_a = 1'b0;
    bus.upd_b = 1'b0;
  endtask

  // Wait for a conversion to start and finish, then for the DONE edge.
  task automatic wait_done(string name);
    int n = 0;
    while (bus.busy !== 1'b1 && n < 8) begin tick(); n++; end
    check({name, "_started"}, int'(bus.busy), 1);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin tick(); n++; end
    check({name, "_finished"}, int'(bus.busy), 0);
    tick();
  endtask

  // Release hold just long enough for exactly one dwell wrap.
  task automatic force_wrap(bit with_upd_a);
    int k = DWELL - (unheld % DWELL);
    bus.hold = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (i == k - 1 && with_upd_a) bus.upd_a = 1'b1;
      tick();
    end
    bus.upd_a = 1'b0;
    bus.hold  = 1'b1;
  endtask

  initial begin
    int changes, src0, n, target;

    vecs[0] = '{1234,   16'h1234, 1'b0, 1'b0};
    vecs[1] = '{-507,   16'h0507, 1'b1, 1'b0};
    vecs[2] = '{-65536, 16'h9999, 1'b1, 1'b1};
    vecs[3] = '{65535,  16'h9999, 1'b0, 1'b1};
    vecs[4] = '{0,      16'h0000, 1'b0, 1'b0};
    vecs[5] = '{9999,   16'h9999, 1'b0, 1'b0};
    vecs[6] = '{10000,  16'h9999, 1'b0, 1'b1};
    vecs[7] = '{-9999,  16'h9999, 1'b1, 1'b0};
    vecs[8] = '{-1,     16'h0001, 1'b1, 1'b0};
    vecs[9] = '{7,      16'h0007, 1'b0, 1'b0};

    rst = 1'b0;
    bus.val_a = '0; bus.val_b = '0;
    bus.upd_a = 1'b0; bus.upd_b = 1'b0;
    bus.hold = 1'b1;
    tick();

    // Reset held 3 cycles with upd_a pulsing.
    for (int i = 0; i < 3; i++) begin
      bus.upd_a = 1'b1;
      tick();
      check($sformatf("reset_outs_%0d", i), outs_packed(), 0);
    end
    bus.upd_a = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    check("reset_no_conversion", int'(bus.busy), 0);

    // Table of conversions of source A.
    foreach (vecs[i]) begin
      va = vecs[i].val;
      bus.val_a = 17'(va);
      pulse(0);
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d_digits", i), shown_digits(), int'(vecs[i].digits));
      check($sformatf("vec%0d_neg", i), int'(bus.neg), int'(vecs[i].neg));
      check($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(vecs[i].ovf));
      check($sformatf("vec%0d_src", i), int'(bus.src), 0);
    end

    // Update during an active conversion: operand unchanged, one follow-up.
    busy_runs.delete();
    va = 100; bus.val_a = 17'(va);
    pulse(0);
    n = 0;
    while (bus.busy !== 1'b1 && n < 8) begin tick(); n++; end
    repeat (4) tick();
    va = 200; bus.val_a = 17'(va);
    pulse(0);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin tick(); n++; end
    tick();
    check_shown("mid_first", 100, 0);
    check("mid_idle_gap", int'(bus.busy), 0);
    tick();
    check("mid_restart", int'(bus.busy), 1);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin tick(); n++; end
    tick();
    check_shown("mid_second", 200, 0);
    tick();
    check("mid_runs", busy_runs.size(), 2);
    check("mid_run0_len", busy_runs.size() > 0 ? busy_runs[0] : -1, 15);
    check("mid_run1_len", busy_runs.size() > 1 ? busy_runs[1] : -1, 15);

    // upd_b while source A is next: ignored.
    busy_runs.delete();
    vb = -321; bus.val_b = 17'(vb);
    pulse(1);
    repeat (20) tick();
    check("updb_ignored", busy_runs.size() + int'(bus.busy), 0);

    // Dwell wrap and upd_a in the same cycle: one conversion of B.
    force_wrap(1'b1);
    wait_done("wrap_upd");
    check_shown("wrap_upd", vb, 1);
    repeat (30) tick();
    check("wrap_upd_runs", busy_runs.size(), 1);

    // Free-running alternation with A=42, B=-9.
    va = 42; vb = -9;
    bus.val_a = 17'(va); bus.val_b = 17'(vb);
    force_wrap(1'b0);
    bus.hold = 1'b0;
    for (int w = 0; w < 6; w++) begin
      repeat (20) tick();
      check_shown($sformatf("alt%0d", w), model_ns() ? vb : va, model_ns());
      repeat (20) tick();
    end
    repeat (20) tick();
    bus.hold = 1'b1;
    src0 = int'(bus.src);
    changes = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (int'(bus.src) != src0) changes++;
    end
    check("hold_src_changes", changes, 0);
    check("hold_src_value", int'(bus.src), model_ns());

    // Randomized conversions of either source.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(1) == 0) begin
        va = int'($urandom_range(131071)) - 65536;
        vb = int'($urandom_range(24000)) - 12000;
      end else begin
        va = int'($urandom_range(24000)) - 12000;
        vb = int'($urandom_range(131071)) - 65536;
      end
      bus.val_a = 17'(va); bus.val_b = 17'(vb);
      target = int'($urandom_range(1));
      if (target != model_ns()) force_wrap(1'b0);
      else pulse(target);
      wait_done($sformatf("rnd%0d", it));
      check_shown($sformatf("rnd%0d", it), target ? vb : va, target);
    end

    // Reset during SHIFT iteration 7 after a visible non-zero result.
    bus.hold = 1'b1;
    force_wrap(1'b0);
    wait_done("pre_a");
    if (model_ns() != 0) begin
      force_wrap(1'b0);
      wait_done("pre_b");
    end
    va = 5555; bus.val_a = 17'(va);
    pulse(0);
    wait_done("pre_rst");
    check_shown("pre_rst", va, 0);
    va = 1111; bus.val_a = 17'(va);
    pulse(0);
    n = 0;
    while (bus.busy !== 1'b1 && n < 8) begin tick(); n++; end
    repeat (8) tick();
    rst = 1'b0;
    tick();
    check("rst_mid_outs", outs_packed(), 0);
    busy_runs.delete();
    run_len = 0;
    rst = 1'b1;
    repeat (30) tick();
    check("rst_mid_no_stale", outs_packed(), 0);
    check("rst_mid_no_runs", busy_runs.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the four-digit-plus-sign seven-segment display between two 17-bit two's-complement sources: A (score) and B (streak/combo).
- Alternates the shown source every DWELL_CYCLES.
- Converts the selected value to sign + four BCD digits with an iterative shift-add-3 engine, replacing combinational divide/modulo.
- Outputs are registered BCD digits that feed the existing seven-segment decoders.

Parameters:
- DWELL_CYCLES, 50000000: cycles each source is shown before switching (1 s at 50 MHz). Must be ≥ 32.
- MAX_MAG, 9999: largest displayable magnitude. Larger magnitudes saturate.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- val_a  in  17  source A value, two's complement
- upd_a  in  1  1-cycle pulse: val_a changed
- val_b  in  17  source B value, two's complement
- upd_b  in  1  1-cycle pulse: val_b changed
- hold  in  1  1 = freeze source alternation; dwell counter held
- dig0  out  4  ones digit, BCD
- dig1  out  4  tens digit, BCD
- dig2  out  4  hundreds digit, BCD
- dig3  out  4  thousands digit, BCD
- neg  out  1  shown value is negative
- ovf  out  1  shown magnitude was saturated
- src  out  1  source being shown: 0 = A, 1 = B
- busy  out  1  conversion in progress

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs go to 0, state goes to IDLE, dwell counter to 0, pending flag cleared.
  - Reset mid-conversion aborts it; no partial digits are ever visible.
- Dwell counter:
  - Increments each cycle while hold=0.
  - On reaching DWELL_CYCLES-1 it wraps to 0, toggles the internal next_src, and sets pending.
  - hold=1 freezes the counter and next_src.
- Update pulses:
  - upd_a sets pending only when next_src=0; upd_b only when next_src=1.
  - Pulses for the non-selected source are ignored, since that value is converted fresh at its next turn.
- Same-cycle events: a dwell wrap and an update pulse in the same cycle produce a single pending conversion of the new next_src.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: if pending, clear pending and go to LOAD. busy=0.
  - LOAD (1 cycle):
    - Sample val_{next_src} into the operand register; record sgn = bit16.
    - mag = sgn ? -val : val, computed at 18 bits so that -65536 yields 65536.
    - If mag > MAX_MAG: set sat=1 and mag = MAX_MAG.
    - Clear the 16-bit BCD accumulator; iteration count = 0. busy=1.
  - SHIFT (14 cycles):
    - Each cycle, first add 3 to every BCD nibble ≥ 5.
    - Then shift {bcd, mag[13:0]} left by 1.
    - After iteration 13, go to DONE.
  - DONE (1 cycle):
    - dig3..dig0 <= bcd nibbles; neg <= sgn; ovf <= sat; src <= captured next_src.
    - busy=0 from this cycle on; go to IDLE.
- Latency: 16 cycles from the IDLE cycle that sees pending to outputs updated (LOAD 1 + SHIFT 14 + DONE 1). Outputs change only in DONE.
- Events during a conversion:
  - upd/dwell events while busy set pending; they never alter the operand in flight.
  - A new conversion starts in the IDLE cycle right after DONE.
  - Multiple events collapse into one conversion.
- Width rules:
  - 17-bit input range is -65536..65535.
  - Magnitude is held at 18 bits until saturation, then 14 bits.
  - Zero always shows neg=0.
- Leading zeros are emitted as digit 0; blanking is done downstream.

Test Plan:
- Reset, then hold rst=0 for 3 cycles with upd_a pulsing → all outputs 0, busy stays 0. Release rst, val_a=1234, pulse upd_a → 16 cycles later dig3..0=1,2,3,4, neg=0, ovf=0, src=0.
- val_a=-507, upd_a → digits 0,5,0,7, neg=1, ovf=0. val_a=-65536, upd_a → 9,9,9,9, neg=1, ovf=1. val_a=65535 → 9,9,9,9, neg=0, ovf=1.
- DWELL_CYCLES=40, val_a=42, val_b=-9, hold=0 → src alternates 0/1 every 40 cycles: src=0 shows 0,0,4,2 with neg=0; src=1 shows 0,0,0,9 with neg=1. Assert hold=1 → src stays constant for 200 cycles.
- Pulse upd_a at cycle 5 of an active conversion with val_a changed from 100 to 200 → first DONE shows 0100, second conversion starts the cycle after, ends with 0200, busy high for 15 cycles each time.
- Pulse upd_b while src=0 and no dwell wrap → no conversion, busy stays 0. Dwell wrap and upd_a in the same cycle → exactly one conversion of source B.
- Drive rst=0 during SHIFT iteration 7 → outputs 0 and busy 0 next cycle; no stale digits appear after release.
